// File: rtl/gon_gather_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gon_gather_sequencer
// Summary  : Gather-side X-bus slave driver. It sweeps a range of column tags
//            and captures PE values into a small FIFO for GLB writeback.
//            The optional skip-on-timeout is enabled by GON_GATHER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gon_gather_sequencer #(
  parameter int ID_LEN     = 5,
  parameter int VALUE_LEN  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ID_LEN-1:0]    tag_base,
  input  logic [ID_LEN:0]      tag_count,
  output logic                 busy,
  output logic                 done,
  output logic [ID_LEN:0]      ready_tag,
  input  logic [VALUE_LEN:0]   enable_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ID_LEN-1:0]    out_tag,
  output logic [VALUE_LEN-1:0] out_data,
  output logic                 timeout_err
);

  localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam int c_entry_w = ID_LEN + VALUE_LEN;

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_issue = 2'd1;
  localparam logic [1:0] c_drain = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [ID_LEN-1:0]    r_cur_tag;
  logic [ID_LEN:0]      r_remaining;
  logic [c_entry_w-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w:0]     r_count;
  logic [c_entry_w-1:0] w_head;

  logic w_full;
  logic w_empty;
  logic w_ready;
  logic w_enable;
  logic w_capture;
  logic w_skip;
  logic w_advance;
  logic w_pop;
  logic w_start_ok;
  logic w_last;

  assign w_full     = (r_count == (c_ptr_w+1)'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_ready    = (r_state == c_issue) && !w_full;
  assign w_enable   = enable_value[VALUE_LEN];
  assign w_capture  = w_ready && w_enable;
  assign w_advance  = w_capture || w_skip;
  assign w_pop      = !w_empty && out_ready;
  assign w_start_ok = start && (r_state == c_idle);
  assign w_last     = (r_remaining == (ID_LEN+1)'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle: begin
        if (start) begin
          w_next_state = (tag_count == '0) ? c_drain : c_issue;
        end
      end
      c_issue: begin
        if (w_advance && w_last) begin
          w_next_state = c_drain;
        end
      end
      c_drain: begin
        if (w_empty) begin
          w_next_state = c_idle;
        end
      end
      default: w_next_state = c_idle;
    endcase
  end

  always_comb begin
    busy      = (r_state != c_idle);
    done      = (r_state == c_drain) && w_empty;
    ready_tag = '0;
    if (r_state == c_issue) begin
      ready_tag = {w_ready, r_cur_tag};
    end
  end

  // Tag walk; the tag wraps naturally at 2^ID_LEN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_tag   <= '0;
      r_remaining <= '0;
    end else if (w_start_ok) begin
      r_cur_tag   <= tag_base;
      r_remaining <= tag_count;
    end else if (w_advance) begin
      r_cur_tag   <= r_cur_tag + 1'b1;
      r_remaining <= r_remaining - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_capture) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + {{c_ptr_w{1'b0}}, w_capture} - {{c_ptr_w{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem[r_wr_ptr] <= {r_cur_tag, enable_value[VALUE_LEN-1:0]};
    end
  end

  // Head is masked so stale storage never shows on an empty FIFO.
  assign w_head    = r_mem[r_rd_ptr];
  assign out_valid = !w_empty;
  assign out_tag   = w_empty ? '0 : w_head[c_entry_w-1:VALUE_LEN];
  assign out_data  = w_empty ? '0 : w_head[VALUE_LEN-1:0];

`ifdef GON_GATHER_TIMEOUT_EN
  localparam int c_wait_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [c_wait_w-1:0] r_wait_cnt;
  logic                r_timeout_err;

  // Only cycles actually offered to the PE (ready=1) count toward the limit.
  assign w_skip = w_ready && !w_enable && (r_wait_cnt == c_wait_w'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || w_advance || (r_state != c_issue)) begin
      r_wait_cnt <= '0;
    end else if (w_ready && !w_enable) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_start_ok) begin
      r_timeout_err <= 1'b0;
    end else if (w_skip) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_skip      = 1'b0;
  // Without the counter a tag is retried forever; the flag can never rise.
  assign timeout_err = (TIMEOUT < 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_gon_gather_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gon_gather_sequencer
// Summary  : Directed self-checking bench for gon_gather_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gon_gather_sequencer;

  localparam int ID_LEN     = 5;
  localparam int VALUE_LEN  = 32;
  localparam int FIFO_DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [ID_LEN-1:0]    tag_base;
  logic [ID_LEN:0]      tag_count;
  logic                 busy;
  logic                 done;
  logic [ID_LEN:0]      ready_tag;
  logic [VALUE_LEN:0]   enable_value;
  logic                 out_valid;
  logic                 out_ready;
  logic [ID_LEN-1:0]    out_tag;
  logic [VALUE_LEN-1:0] out_data;
  logic                 timeout_err;

  always #5 clk = ~clk;

  gon_gather_sequencer #(
    .ID_LEN     (ID_LEN),
    .VALUE_LEN  (VALUE_LEN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (15)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .tag_base     (tag_base),
    .tag_count    (tag_count),
    .busy         (busy),
    .done         (done),
    .ready_tag    (ready_tag),
    .enable_value (enable_value),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_tag      (out_tag),
    .out_data     (out_data),
    .timeout_err  (timeout_err)
  );

  // PE responder: answers 0xA0000000|tag at once unless its tag is stalled.
  logic [ID_LEN-1:0] stall_tag;
  int                stall_len;
  int                stall_used;
  logic              stall_clr;

  always_comb begin
    enable_value = '0;
    if (ready_tag[ID_LEN]) begin
      enable_value[VALUE_LEN-1:0] = 32'hA000_0000 | {27'd0, ready_tag[ID_LEN-1:0]};
      enable_value[VALUE_LEN]     = !((ready_tag[ID_LEN-1:0] == stall_tag) && (stall_used < stall_len));
    end
  end

  always @(posedge clk) begin
    if (stall_clr) begin
      stall_used <= 0;
    end else if (ready_tag[ID_LEN] && (ready_tag[ID_LEN-1:0] == stall_tag) && (stall_used < stall_len)) begin
      stall_used <= stall_used + 1;
    end
  end

  // Bus monitor
  int                cyc = 0;
  int                ready_cnt = 0;
  int                stall_seen = 0;
  int                done_cnt = 0;
  int                done_bad = 0;
  logic [ID_LEN-1:0] cap_q [$];
  int                cap_cyc [$];
  logic [36:0]       out_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ready_tag[ID_LEN]) begin
      ready_cnt <= ready_cnt + 1;
      if (enable_value[VALUE_LEN]) begin
        cap_q.push_back(ready_tag[ID_LEN-1:0]);
        cap_cyc.push_back(cyc);
      end else if (ready_tag[ID_LEN-1:0] == stall_tag) begin
        stall_seen <= stall_seen + 1;
      end
    end
    if (out_valid && out_ready) out_q.push_back({out_tag, out_data});
    if (done) begin
      done_cnt <= done_cnt + 1;
      if (out_valid) done_bad <= done_bad + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [36:0] exp_entry(input logic [4:0] t);
    return {t, 32'hA000_0000 | {27'd0, t}};
  endfunction

  task automatic cyc_in();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    cap_q.delete();
    cap_cyc.delete();
    out_q.delete();
  endtask

  task automatic pulse_start(input logic [4:0] b, input logic [5:0] c);
    tag_base  = b;
    tag_count = c;
    start     = 1'b1;
    cyc_in();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) cyc_in();
    check(name, 64'(done_cnt != d0), 64'd1);
  endtask

  task automatic check_outputs(input logic [4:0] first, input int n, input string name);
    logic [4:0] t;
    check({name, "_n"}, 64'(out_q.size()), 64'(n));
    t = first;
    for (int i = 0; i < n && i < out_q.size(); i++) begin
      check({name, "_entry"}, 64'(out_q[i]), 64'(exp_entry(t)));
      t = t + 5'd1;
    end
  endtask

  initial begin
    int d0;
    int r0;
    int s0;

    rst = 1'b1; start = 1'b0; tag_base = '0; tag_count = '0; out_ready = 1'b0;
    stall_tag = 5'd31; stall_len = 0; stall_clr = 1'b1;
    repeat (3) cyc_in();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready_tag", 64'(ready_tag), 64'd0);
    check("rst_out", 64'({out_valid, out_tag, out_data}), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    rst = 1'b0; stall_clr = 1'b0;
    cyc_in();

    // Basic sweep 3..6, consumer always ready
    clear_logs(); out_ready = 1'b1; d0 = done_cnt;
    pulse_start(5'd3, 6'd4);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done(30, "t1_done");
    check("t1_busy_fall", 64'(busy), 64'd0);
    check("t1_done_once", 64'(done_cnt - d0), 64'd1);
    check("t1_ncap", 64'(cap_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      check("t1_cap_tag", 64'(cap_q[i]), 64'(3 + i));
      check("t1_consec", 64'(cap_cyc[i] - cap_cyc[0]), 64'(i));
    end
    check_outputs(5'd3, 4, "t1_out");

    // Tag wrap 30,31,0,1
    clear_logs();
    pulse_start(5'd30, 6'd4);
    wait_done(30, "t2_done");
    check_outputs(5'd30, 4, "t2_out");

    // Backpressure: FIFO fills, ready drops, then drains in order
    clear_logs(); out_ready = 1'b0; d0 = done_cnt;
    pulse_start(5'd0, 6'd6);
    repeat (10) cyc_in();
    check("t3_ncap_full", 64'(cap_q.size()), 64'd4);
    check("t3_ready_low", 64'(ready_tag[ID_LEN]), 64'd0);
    check("t3_head", 64'({out_valid, out_tag, out_data}), 64'({1'b1, exp_entry(5'd0)}));
    check("t3_no_done", 64'(done_cnt - d0), 64'd0);
    out_ready = 1'b1;
    wait_done(40, "t3_done");
    check_outputs(5'd0, 6, "t3_out");
    check("t3_done_empty", 64'(done_bad), 64'd0);

    // PE for tag 2 withholds enable for 5 offered cycles
    clear_logs(); stall_tag = 5'd2; stall_len = 5;
    stall_clr = 1'b1; cyc_in(); stall_clr = 1'b0;
    s0 = stall_seen;
    pulse_start(5'd1, 6'd3);
    wait_done(40, "t4_done");
    check("t4_stall_cycles", 64'(stall_seen - s0), 64'd5);
    if (cap_cyc.size() >= 2) check("t4_cap_gap", 64'(cap_cyc[1] - cap_cyc[0]), 64'd6);
    else check("t4_cap_gap", 64'(cap_cyc.size()), 64'd2);
    check_outputs(5'd1, 3, "t4_out");
    check("t4_timeout_err", 64'(timeout_err), 64'd0);
    stall_len = 0;

    // Zero-length sweep
    clear_logs(); r0 = ready_cnt; d0 = done_cnt;
    pulse_start(5'd7, 6'd0);
    wait_done(2, "t5_done_fast");
    check("t5_no_ready", 64'(ready_cnt - r0), 64'd0);
    check("t5_busy_fall", 64'(busy), 64'd0);

    // Start while busy is ignored
    clear_logs(); d0 = done_cnt;
    pulse_start(5'd10, 6'd2);
    tag_base = 5'd20; tag_count = 6'd5; start = 1'b1;
    cyc_in();
    start = 1'b0;
    wait_done(30, "t5_busy_done");
    check("t5_busy_ncap", 64'(cap_q.size()), 64'd2);
    check_outputs(5'd10, 2, "t5_busy_out");
    check("t5_busy_done_once", 64'(done_cnt - d0), 64'd1);

    // Reset mid-sweep with two entries held
    clear_logs(); out_ready = 1'b0; d0 = done_cnt;
    pulse_start(5'd0, 6'd6);
    for (int i = 0; i < 20 && cap_q.size() < 2; i++) cyc_in();
    check("t6_two_entries", 64'(cap_q.size()), 64'd2);
    rst = 1'b1;
    cyc_in();
    check("t6_rst_outs", 64'({busy, done, ready_tag, out_valid, out_tag, out_data, timeout_err}), 64'd0);
    rst = 1'b0;
    repeat (4) cyc_in();
    check("t6_no_done", 64'(done_cnt - d0), 64'd0);
    check("t6_idle", 64'({busy, out_valid}), 64'd0);
    clear_logs(); out_ready = 1'b1;
    pulse_start(5'd4, 6'd2);
    wait_done(30, "t6_restart_done");
    check_outputs(5'd4, 2, "t6_restart_out");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
